// File: rtl/game_pkg.sv
// game_pkg: shared screen encodings, RGB565 colours and OLED geometry
package game_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } state_t;

    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] YELLOW = 16'hFFC2;
    localparam logic [15:0] PINK   = 16'hFC0D;
    localparam logic [15:0] BLUE   = 16'h001F;
    localparam logic [15:0] ORANGE = 16'hFD20;
    localparam logic [15:0] GREEN  = 16'h07E0;

    localparam int OLED_W = 96;
    localparam int OLED_H = 64;

endpackage

// File: rtl/pulse_divider.sv
// pulse_divider: free-running 0..DIV-1 counter emitting a one-cycle pulse on its wrap cycle
module pulse_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic pulse
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt_q;

    assign pulse = (cnt_q == W'(DIV - 1));

    // count up, restarting from zero on wrap, clear or reset
    always_ff @(posedge clk) begin
        if (reset || clr || pulse) cnt_q <= '0;
        else                       cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/game_screen_sequencer.sv
// game_screen_sequencer: game-flow FSM, countdown timer, strike counter and registered pixel mux
module game_screen_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int TIME_LIMIT  = 60,
    parameter int MAX_STRIKES = 3,
    parameter int FLASH_DIV   = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        defused,
    input  logic        strike,
    input  logic [15:0] px_start,
    input  logic [15:0] px_game,
    input  logic [15:0] px_win,
    input  logic [15:0] px_lose,
    output logic [15:0] oled_data,
    output logic [1:0]  state,
    output logic [6:0]  time_left,
    output logic [1:0]  strikes,
    output logic        game_en,
    output logic        puzzle_rst
);

    state_t      state_q;
    logic [6:0]  time_q;
    logic [1:0]  strikes_q;
    logic [15:0] oled_q;
    logic [15:0] px_d;
    logic        btn_prev_q;
    logic        flash_q;
    logic        puzzle_rst_q;
    logic        press;
    logic        start_go;
    logic        go_lose;
    logic        tick;
    logic        flash_pulse;

    assign press    = btn_start & ~btn_prev_q;
    assign start_go = (state_q == ST_START) && press;
    // defused wins; otherwise the last second running out or the final strike both end the game
    assign go_lose  = (state_q == ST_PLAY) && !defused &&
                      ((tick && time_q == 7'd1) || (strike && strikes_q == 2'(MAX_STRIKES - 1)));

    pulse_divider #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (start_go),
        .pulse (tick)
    );

    pulse_divider #(.DIV(FLASH_DIV)) u_flash (
        .clk   (clk),
        .reset (reset),
        .clr   (go_lose),
        .pulse (flash_pulse)
    );

    assign px_d = (state_q == ST_PLAY) ? px_game :
                  (state_q == ST_WIN)  ? px_win  :
                  (state_q == ST_LOSE) ? (flash_q ? RED : px_lose) : px_start;

    // screen sequencing with registered pixel stream, counters and puzzle clear pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_START;
            oled_q       <= BLACK;
            time_q       <= 7'(TIME_LIMIT);
            strikes_q    <= '0;
            puzzle_rst_q <= 1'b0;
            flash_q      <= 1'b0;
            btn_prev_q   <= 1'b1;
        end else begin
            btn_prev_q   <= btn_start;
            oled_q       <= px_d;
            puzzle_rst_q <= 1'b0;
            case (state_q)
                ST_START: begin
                    if (press) begin
                        state_q      <= ST_PLAY;
                        puzzle_rst_q <= 1'b1;
                        time_q       <= 7'(TIME_LIMIT);
                        strikes_q    <= '0;
                    end
                end
                ST_PLAY: begin
                    if (defused) begin
                        state_q <= ST_WIN;
                    end else begin
                        if (tick && time_q != 7'd0) time_q <= time_q - 7'd1;
                        if (strike && strikes_q != 2'(MAX_STRIKES)) strikes_q <= strikes_q + 2'd1;
                        if (go_lose) begin
                            state_q <= ST_LOSE;
                            flash_q <= 1'b0;
                        end
                    end
                end
                ST_WIN: begin
                    if (press) state_q <= ST_START;
                end
                ST_LOSE: begin
                    if (flash_pulse) flash_q <= ~flash_q;
                    if (press) state_q <= ST_START;
                end
            endcase
        end
    end

    assign oled_data  = oled_q;
    assign state      = state_q;
    assign time_left  = time_q;
    assign strikes    = strikes_q;
    assign game_en    = (state_q == ST_PLAY);
    assign puzzle_rst = puzzle_rst_q;

endmodule
